score_counter: RTL

Gameplay score keeper for the dino game. It sits between `player_controller` (game-state pulses) and `score_render` (digit display), and drives the render block's `num` input.
- Counts elapsed 20 Hz game ticks into a packed-BCD score.
- Clears the score on game start and freezes it on game over.
- Keeps a session high score and emits a one-cycle milestone pulse every 100 points for display effects.

---
 rtl/dino_pkg.sv | 13 +
 rtl/bcd_digit.sv | 24 ++
 rtl/score_counter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/dino_pkg.sv
// Types and constants shared across the dino game blocks (score_counter, score_render).
package dino_pkg;

  localparam int BCD_W          = 4;
  localparam int DIGITS_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    OVER    = 2'd2
  } score_state_t;

endpackage

// File: rtl/bcd_digit.sv
// One packed-BCD digit incrementer; digits chain through inc_in/carry_out.
module bcd_digit
  import dino_pkg::*;
(
  input  logic [BCD_W-1:0] digit_in,
  input  logic             inc_in,
  output logic [BCD_W-1:0] digit_out,
  output logic             carry_out
);

  always_comb begin
    digit_out = digit_in;
    carry_out = 1'b0;
    if (inc_in) begin
      if (digit_in == 4'd9) begin
        digit_out = 4'd0;
        carry_out = 1'b1;
      end else begin
        digit_out = digit_in + 4'd1;
      end
    end
  end

endmodule

// File: rtl/score_counter.sv
// Dino game score keeper: BCD score, session high score, 100-point milestone pulse.
// High score logic is built only when SCORE_HISCORE_EN is defined; otherwise hi_score is 0.
module score_counter
  import dino_pkg::*;
#(
  parameter int DIGITS              = DIGITS_DEFAULT,
  parameter int TICKS_PER_POINT     = 2,
  parameter int MILESTONE_EN_DIGITS = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    game_tick,
  input  logic                    game_start_pulse,
  input  logic                    game_over_pulse,
  output logic [BCD_W*DIGITS-1:0] score,
  output logic [BCD_W*DIGITS-1:0] hi_score,
  output logic                    running,
  output logic                    milestone_pulse,
  output score_state_t            dbg_state
);

  localparam int SW = BCD_W * DIGITS;
  localparam int MW = BCD_W * MILESTONE_EN_DIGITS;
  localparam logic [7:0] PRESC_LAST = 8'(TICKS_PER_POINT - 1);

  score_state_t r_state;
  logic [SW-1:0] r_score;
  logic [7:0]    r_presc;
  logic          r_running;
  logic          r_milestone;

  logic [SW-1:0]   w_next;
  logic [DIGITS:0] w_carry;
  logic            w_all9;
  logic            w_low_zero;
  logic            w_go_over;

  // Chain is always fed a +1; its final carry doubles as the all-9s detect.
  assign w_carry[0] = 1'b1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .digit_in  (r_score[g*BCD_W +: BCD_W]),
      .inc_in    (w_carry[g]),
      .digit_out (w_next[g*BCD_W +: BCD_W]),
      .carry_out (w_carry[g+1])
    );
  end

  assign w_all9     = w_carry[DIGITS];
  assign w_low_zero = (w_next[MW-1:0] == '0);
  assign w_go_over  = (r_state == RUNNING) && game_over_pulse;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_score     <= '0;
      r_presc     <= '0;
      r_running   <= 1'b0;
      r_milestone <= 1'b0;
    end else begin
      r_milestone <= 1'b0;
      case (r_state)
        IDLE, OVER: begin
          if (game_start_pulse) begin
            r_state   <= RUNNING;
            r_running <= 1'b1;
            r_score   <= '0;
            r_presc   <= '0;
          end
        end
        RUNNING: begin
          if (game_over_pulse) begin
            r_state   <= OVER;
            r_running <= 1'b0;
          end else if (game_tick) begin
            if (r_presc == PRESC_LAST) begin
              r_presc <= '0;
              if (!w_all9) begin
                r_score     <= w_next;
                r_milestone <= w_low_zero;
              end
            end else begin
              r_presc <= r_presc + 8'd1;
            end
          end
        end
        default: begin
          r_state   <= IDLE;
          r_running <= 1'b0;
        end
      endcase
    end
  end

`ifdef SCORE_HISCORE_EN
  logic [SW-1:0] r_hi;

  // Most significant differing digit decides the order.
  function automatic logic bcd_gt(input logic [SW-1:0] a, input logic [SW-1:0] b);
    logic decided;
    logic gt;
    decided = 1'b0;
    gt      = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (!decided && (a[i*BCD_W +: BCD_W] != b[i*BCD_W +: BCD_W])) begin
        decided = 1'b1;
        gt      = (a[i*BCD_W +: BCD_W] > b[i*BCD_W +: BCD_W]);
      end
    end
    return gt;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi <= '0;
    end else if (w_go_over && bcd_gt(r_score, r_hi)) begin
      r_hi <= r_score;
    end
  end

  assign hi_score = r_hi;
`else
  assign hi_score = '0;
`endif

  assign score           = r_score;
  assign running         = r_running;
  assign milestone_pulse = r_milestone;
  assign dbg_state       = r_state;

endmodule
